// File: rtl/pong_pkg.sv
// Shared definitions for the pong scoreboard path.
//   - Digit box size, segment rectangle bands and the blank pattern.
//   - Game state enum.
//   - BCD increment and BCD->binary helpers.
//   - Small geometry helpers used by the pixel renderer.
package pong_pkg;

  localparam logic [9:0] DIGIT_W   = 10'd26;
  localparam logic [9:0] DIGIT_H   = 10'd39;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment column bands, relative to the slot origin (inclusive bounds)
  localparam logic [5:0] SEG_XL_LO = 6'd0;   // e, f
  localparam logic [5:0] SEG_XL_HI = 6'd4;
  localparam logic [5:0] SEG_XM_LO = 6'd5;   // a, g, d
  localparam logic [5:0] SEG_XM_HI = 6'd20;
  localparam logic [5:0] SEG_XR_LO = 6'd21;  // b, c
  localparam logic [5:0] SEG_XR_HI = 6'd25;

  // Segment row bands, relative to the slot origin (inclusive bounds)
  localparam logic [5:0] SEG_YT_LO = 6'd0;   // a
  localparam logic [5:0] SEG_YT_HI = 6'd4;
  localparam logic [5:0] SEG_YU_LO = 6'd5;   // b, f
  localparam logic [5:0] SEG_YU_HI = 6'd16;
  localparam logic [5:0] SEG_YM_LO = 6'd17;  // g
  localparam logic [5:0] SEG_YM_HI = 6'd21;
  localparam logic [5:0] SEG_YL_LO = 6'd22;  // c, e
  localparam logic [5:0] SEG_YL_HI = 6'd33;
  localparam logic [5:0] SEG_YB_LO = 6'd34;  // d
  localparam logic [5:0] SEG_YB_HI = 6'd38;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  // Two-digit BCD increment, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  function automatic logic in_band(input logic [5:0] v,
                                   input logic [5:0] lo,
                                   input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Pixel (px, py) inside the DIGIT_W x DIGIT_H box anchored at (sx, sy)
  function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] sx, input logic [9:0] sy);
    return (px >= sx) && ((px - sx) < DIGIT_W) &&
           (py >= sy) && ((py - sy) < DIGIT_H);
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// BCD digit to active-low seven-segment pattern.
//   i_digit : 4-bit digit code; 10..15 decode to all-off
//   o_seg   : segments, bit 0 = a ... bit 6 = g, 0 = lit
import pong_pkg::*;

module seven_seg_decode (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = 7'h40;
      4'd1: o_seg = 7'h79;
      4'd2: o_seg = 7'h24;
      4'd3: o_seg = 7'h30;
      4'd4: o_seg = 7'h19;
      4'd5: o_seg = 7'h12;
      4'd6: o_seg = 7'h02;
      4'd7: o_seg = 7'h78;
      4'd8: o_seg = 7'h00;
      4'd9: o_seg = 7'h10;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_board_ctrl.sv
// Pong scoreboard controller.
// Keeps both players' BCD scores, detects the winner, sequences game over /
// restart, and renders the four score digits into a registered pixel flag.
//   clk, reset        : clock, synchronous active-high reset
//   point_p1/point_p2 : scoring levels from the ball logic, counted on rise
//   new_game          : restart pulse, honoured only after game over
//   x, y              : current pixel position
//   score_on          : pixel lies on a lit segment (1-clock latency)
//   game_over, winner : game finished / who won (0 = p1, 1 = p2)
//   p1_bcd, p2_bcd    : scores as {tens, units}
import pong_pkg::*;

module score_board_ctrl #(
  parameter int unsigned WIN_SCORE   = 11,
  parameter logic [9:0]  P1_X        = 10'd240,
  parameter logic [9:0]  P2_X        = 10'd360,
  parameter logic [9:0]  DIGIT_Y     = 10'd20,
  parameter logic [9:0]  DIGIT_PITCH = 10'd32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       score_on,
  output logic       game_over,
  output logic       winner,
  output logic [7:0] p1_bcd,
  output logic [7:0] p2_bcd
);

  localparam logic [6:0] WIN_BIN = 7'(WIN_SCORE);
  localparam logic [9:0] P1U_X   = P1_X + DIGIT_PITCH;
  localparam logic [9:0] P2U_X   = P2_X + DIGIT_PITCH;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_p1_q;
  logic       r_p2_q;
  logic       r_winner;
  logic       w_winner_next;
  logic [7:0] r_p1_bcd;
  logic [7:0] r_p2_bcd;
  logic [7:0] w_p1_next;
  logic [7:0] w_p2_next;
  logic [7:0] w_p1_inc;
  logic [7:0] w_p2_inc;
  logic       w_rise_p1;
  logic       w_rise_p2;
  logic       r_score_on;

  // ---------------------------------------------------------------------------
  // Point edge detection
  // ---------------------------------------------------------------------------
  assign w_rise_p1 = point_p1 & ~r_p1_q;
  assign w_rise_p2 = point_p2 & ~r_p2_q;
  assign w_p1_inc  = bcd_inc(r_p1_bcd);
  assign w_p2_inc  = bcd_inc(r_p2_bcd);

  // ---------------------------------------------------------------------------
  // FSM: state / score registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= PLAY;
      r_p1_q   <= 1'b0;
      r_p2_q   <= 1'b0;
      r_winner <= 1'b0;
      r_p1_bcd <= '0;
      r_p2_bcd <= '0;
    end else begin
      r_state  <= w_state_next;
      r_p1_q   <= point_p1;
      r_p2_q   <= point_p2;
      r_winner <= w_winner_next;
      r_p1_bcd <= w_p1_next;
      r_p2_bcd <= w_p2_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and score update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_winner_next = r_winner;
    w_p1_next     = r_p1_bcd;
    w_p2_next     = r_p2_bcd;
    case (r_state)
      PLAY: begin
        // simultaneous rises void the rally
        if (w_rise_p1 && !w_rise_p2) begin
          w_p1_next = w_p1_inc;
          if (bcd_to_bin(w_p1_inc) == WIN_BIN) begin
            w_state_next  = OVER;
            w_winner_next = 1'b0;
          end
        end else if (w_rise_p2 && !w_rise_p1) begin
          w_p2_next = w_p2_inc;
          if (bcd_to_bin(w_p2_inc) == WIN_BIN) begin
            w_state_next  = OVER;
            w_winner_next = 1'b1;
          end
        end
      end
      OVER: begin
        if (new_game) begin
          w_state_next  = PLAY;
          w_winner_next = 1'b0;
          w_p1_next     = '0;
          w_p2_next     = '0;
        end
      end
      default: w_state_next = PLAY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    game_over = (r_state == OVER);
    winner    = r_winner;
    p1_bcd    = r_p1_bcd;
    p2_bcd    = r_p2_bcd;
    score_on  = r_score_on;
  end

  // ---------------------------------------------------------------------------
  // Slot select: first hit in order P1T, P1U, P2T, P2U
  // ---------------------------------------------------------------------------
  logic [3:0] w_hit;
  logic       w_sel_valid;
  logic       w_sel_tens;
  logic [3:0] w_sel_digit;
  logic [9:0] w_sel_x;
  logic [5:0] w_dx;
  logic [5:0] w_dy;
  logic [6:0] w_dec_seg;
  logic [6:0] w_seg;
  logic [6:0] w_seg_area;
  logic       w_lit;

  always_comb begin
    w_hit[0] = in_box(x, y, P1_X,  DIGIT_Y);
    w_hit[1] = in_box(x, y, P1U_X, DIGIT_Y);
    w_hit[2] = in_box(x, y, P2_X,  DIGIT_Y);
    w_hit[3] = in_box(x, y, P2U_X, DIGIT_Y);

    w_sel_valid = 1'b1;
    w_sel_tens  = 1'b0;
    w_sel_digit = '0;
    w_sel_x     = P1_X;
    if (w_hit[0]) begin
      w_sel_tens  = 1'b1;
      w_sel_digit = r_p1_bcd[7:4];
      w_sel_x     = P1_X;
    end else if (w_hit[1]) begin
      w_sel_digit = r_p1_bcd[3:0];
      w_sel_x     = P1U_X;
    end else if (w_hit[2]) begin
      w_sel_tens  = 1'b1;
      w_sel_digit = r_p2_bcd[7:4];
      w_sel_x     = P2_X;
    end else if (w_hit[3]) begin
      w_sel_digit = r_p2_bcd[3:0];
      w_sel_x     = P2U_X;
    end else begin
      w_sel_valid = 1'b0;
    end

    // The offsets are below 64 whenever a slot hits, so only the low bits of
    // the subtraction matter; misses are blanked below anyway.
    w_dx = x[5:0] - w_sel_x[5:0];
    w_dy = y[5:0] - DIGIT_Y[5:0];
  end

  seven_seg_decode u_decode (
    .i_digit (w_sel_digit),
    .o_seg   (w_dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Shared segment renderer
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!w_sel_valid || (w_sel_tens && (w_sel_digit == 4'd0)))
      w_seg = SEG_BLANK;
    else
      w_seg = w_dec_seg;

    w_seg_area[0] = in_band(w_dx, SEG_XM_LO, SEG_XM_HI) && in_band(w_dy, SEG_YT_LO, SEG_YT_HI);
    w_seg_area[1] = in_band(w_dx, SEG_XR_LO, SEG_XR_HI) && in_band(w_dy, SEG_YU_LO, SEG_YU_HI);
    w_seg_area[2] = in_band(w_dx, SEG_XR_LO, SEG_XR_HI) && in_band(w_dy, SEG_YL_LO, SEG_YL_HI);
    w_seg_area[3] = in_band(w_dx, SEG_XM_LO, SEG_XM_HI) && in_band(w_dy, SEG_YB_LO, SEG_YB_HI);
    w_seg_area[4] = in_band(w_dx, SEG_XL_LO, SEG_XL_HI) && in_band(w_dy, SEG_YL_LO, SEG_YL_HI);
    w_seg_area[5] = in_band(w_dx, SEG_XL_LO, SEG_XL_HI) && in_band(w_dy, SEG_YU_LO, SEG_YU_HI);
    w_seg_area[6] = in_band(w_dx, SEG_XM_LO, SEG_XM_HI) && in_band(w_dy, SEG_YM_LO, SEG_YM_HI);

    w_lit = |(~w_seg & w_seg_area);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_score_on <= 1'b0;
    else
      r_score_on <= w_lit;
  end

endmodule

// File: tb/tb_score_board_ctrl.sv
// Scoreboard bench for score_board_ctrl: stimulus pushes expected values
// tagged with the cycle they become visible; a monitor compares them.
module tb_score_board_ctrl;
  import pong_pkg::*;

  localparam logic [9:0] P1_X  = 10'd240;
  localparam logic [9:0] P2_X  = 10'd360;
  localparam logic [9:0] DY    = 10'd20;
  localparam logic [9:0] PITCH = 10'd32;

  localparam int unsigned K_P1  = 0;
  localparam int unsigned K_P2  = 1;
  localparam int unsigned K_GO  = 2;
  localparam int unsigned K_WIN = 3;
  localparam int unsigned K_PIX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic       new_game = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       score_on;
  logic       game_over;
  logic       winner;
  logic [7:0] p1_bcd;
  logic [7:0] p2_bcd;

  score_board_ctrl #(
    .WIN_SCORE   (11),
    .P1_X        (P1_X),
    .P2_X        (P2_X),
    .DIGIT_Y     (DY),
    .DIGIT_PITCH (PITCH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .point_p1  (point_p1),
    .point_p2  (point_p2),
    .new_game  (new_game),
    .x         (x),
    .y         (y),
    .score_on  (score_on),
    .game_over (game_over),
    .winner    (winner),
    .p1_bcd    (p1_bcd),
    .p2_bcd    (p2_bcd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    int unsigned kind;
    logic [7:0]  val;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t keep_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // hand-computed BCD score sequence 1..11
  logic [7:0] seq [11] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h07, 8'h08, 8'h09, 8'h10, 8'h11};

  function automatic logic [7:0] actual(input int unsigned kind);
    case (kind)
      K_P1:    return p1_bcd;
      K_P2:    return p2_bcd;
      K_GO:    return {7'd0, game_over};
      K_WIN:   return {7'd0, winner};
      default: return {7'd0, score_on};
    endcase
  endfunction

  // Monitor: compares every expectation due in the cycle just completed
  always @(negedge clk) begin
    keep_q = {};
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        n_checks++;
        if (actual(q[i].kind) !== q[i].val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %h, expected %h",
                   q[i].name, cyc, actual(q[i].kind), q[i].val);
        end
      end else if (q[i].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never sampled", q[i].name, q[i].due);
      end else begin
        keep_q.push_back(q[i]);
      end
    end
    q = keep_q;
  end

  task automatic expect_next(input int unsigned kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input bit who, input logic [7:0] e1, input logic [7:0] e2, input string nm);
    if (who) point_p2 = 1'b1; else point_p1 = 1'b1;
    expect_next(K_P1, e1, {nm, "_p1"});
    expect_next(K_P2, e2, {nm, "_p2"});
    step();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    step();
  endtask

  task automatic pixel(input logic [9:0] px, input logic [9:0] py, input bit lit, input string nm);
    x = px;
    y = py;
    expect_next(K_PIX, {7'd0, lit}, nm);
    step();
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    step();
    expect_next(K_P1, 8'h00, "rst_p1");
    expect_next(K_GO, 8'h00, "rst_go");
    step();
    reset = 1'b0;
    x = P1_X + 10'd10;
    y = DY + 10'd2;
    expect_next(K_PIX, 8'h00, "blank_tens0");
    expect_next(K_P1, 8'h00, "post_rst_p1");
    expect_next(K_P2, 8'h00, "post_rst_p2");
    expect_next(K_GO, 8'h00, "post_rst_go");
    step();

    // level held for 5 clocks counts once
    point_p1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_next(K_P1, 8'h01, "hold_p1");
      step();
    end
    point_p1 = 1'b0;
    step();

    // digit "1" in P1 units slot
    pixel(P1_X + PITCH + 10'd22, DY + 10'd8, 1'b1, "p1u_seg_b");
    pixel(P1_X + PITCH + 10'd10, DY + 10'd2, 1'b0, "p1u_seg_a_off");

    // 10 player-2 pulses: units wrap 9 -> 0
    for (int i = 0; i < 10; i++)
      pulse(1'b1, 8'h01, seq[i], "p2_count");

    // render "10" for player 2, including box edges
    pixel(P2_X + 10'd22,         DY + 10'd8,  1'b1, "p2t_seg_b");
    pixel(P2_X + PITCH + 10'd10, DY + 10'd2,  1'b1, "p2u_seg_a");
    pixel(P2_X + PITCH + 10'd10, DY + 10'd19, 1'b0, "p2u_seg_g_off");
    pixel(P2_X + PITCH + 10'd10, DY + 10'd38, 1'b1, "p2u_bottom_row");
    pixel(P2_X + PITCH + 10'd10, DY + 10'd39, 1'b0, "p2u_below_box");
    pixel(P2_X + PITCH + 10'd25, DY + 10'd8,  1'b1, "p2u_right_col");
    pixel(P2_X + PITCH + 10'd26, DY + 10'd8,  1'b0, "p2u_past_box");

    // simultaneous rises: rally void
    point_p1 = 1'b1;
    point_p2 = 1'b1;
    expect_next(K_P1, 8'h01, "void_p1");
    expect_next(K_P2, 8'h10, "void_p2");
    step();
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    step();

    // new_game ignored in PLAY
    new_game = 1'b1;
    expect_next(K_P1, 8'h01, "ng_play_p1");
    expect_next(K_GO, 8'h00, "ng_play_go");
    step();
    new_game = 1'b0;

    // player 1 to 11 -> game over, winner p1
    for (int i = 1; i < 11; i++) begin
      if (i == 10) begin
        expect_next(K_GO,  8'h01, "p1_win_go");
        expect_next(K_WIN, 8'h00, "p1_win_winner");
      end else begin
        expect_next(K_GO, 8'h00, "p1_not_yet_go");
      end
      pulse(1'b0, seq[i], 8'h10, "p1_count");
    end

    // frozen in OVER
    pulse(1'b0, 8'h11, 8'h10, "over_p1");
    pulse(1'b1, 8'h11, 8'h10, "over_p2");
    pixel(P1_X + 10'd22, DY + 10'd8, 1'b1, "over_display");

    // restart
    new_game = 1'b1;
    expect_next(K_P1, 8'h00, "restart_p1");
    expect_next(K_P2, 8'h00, "restart_p2");
    expect_next(K_GO, 8'h00, "restart_go");
    step();
    new_game = 1'b0;

    // reach OVER with p2 = 07, then reset
    for (int i = 0; i < 7; i++)
      pulse(1'b1, 8'h00, seq[i], "p2_to7");
    for (int i = 0; i < 11; i++)
      pulse(1'b0, seq[i], 8'h07, "p1_to11");
    x = P1_X + 10'd22;
    y = DY + 10'd8;
    expect_next(K_GO, 8'h01, "over2_go");
    expect_next(K_PIX, 8'h01, "over2_pix");
    step();
    reset = 1'b1;
    expect_next(K_P1,  8'h00, "ovr_rst_p1");
    expect_next(K_P2,  8'h00, "ovr_rst_p2");
    expect_next(K_GO,  8'h00, "ovr_rst_go");
    expect_next(K_WIN, 8'h00, "ovr_rst_winner");
    expect_next(K_PIX, 8'h00, "ovr_rst_pix");
    step();
    reset = 1'b0;
    pulse(1'b0, 8'h01, 8'h00, "first_after_rst");

    // player 2 wins
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        expect_next(K_GO,  8'h01, "p2_win_go");
        expect_next(K_WIN, 8'h01, "p2_win_winner");
      end
      pulse(1'b1, 8'h01, seq[i], "p2_to11");
    end

    step();
    step();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
